// File: rtl/uart_pkg.sv
// Shared definitions for the UART command framer: byte width, transceiver
// bit period, and the RX / TX framer state encodings.
// No ports (package only).
package uart_pkg;

   localparam int BYTE_W   = 8;
   // Bit period of the serial link in clk cycles.
   localparam int BAUD_DIV = 16;

   typedef enum logic {
      RX_IDLE    = 1'b0,
      RX_COLLECT = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_WAIT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/uart_cmd_frame_uart.sv
// Byte-level UART transceiver, 8N1, DIV clk cycles per bit.
// Ports: RX/TX serial lines; rx_data/rx_rdy (level, cleared by clr_rx_rdy);
// trmt starts sending tx_data, tx_done pulses once the stop bit has been sent.
module uart_cmd_frame_uart
   import uart_pkg::*;
#(
   parameter int DIV = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RX,
   output logic              TX,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_rdy,
   input  logic              clr_rx_rdy,
   input  logic              trmt,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_done
);

   localparam int BW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BAUD_MAX  = BW'(DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(DIV / 2);

   // ---------------- receiver ----------------
   logic [1:0]        rx_sync;
   logic              rx_busy;
   logic [BW-1:0]     rx_baud;
   logic [3:0]        rx_bits;
   logic [BYTE_W-1:0] rx_shift;

   // Sample points: start bit at mid-bit, then 8 data bits and the stop bit.
   // The start sample falls off the end of the 8-bit shifter, so after the
   // ninth sample the shifter holds exactly the data bits, LSB at [0].
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_sync  <= 2'b11;
         rx_busy  <= 1'b0;
         rx_baud  <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_rdy   <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], RX};
         if (clr_rx_rdy) rx_rdy <= 1'b0;
         if (!rx_busy) begin
            if (!rx_sync[1]) begin
               rx_busy <= 1'b1;
               rx_baud <= BAUD_HALF;
               rx_bits <= '0;
            end
         end else if (rx_baud != '0) begin
            rx_baud <= rx_baud - 1'b1;
         end else begin
            rx_baud  <= BAUD_MAX;
            rx_shift <= {rx_sync[1], rx_shift[BYTE_W-1:1]};
            rx_bits  <= rx_bits + 1'b1;
            if (rx_bits == 4'd9) begin
               rx_busy <= 1'b0;
               rx_data <= rx_shift;
               rx_rdy  <= 1'b1;
            end
         end
      end
   end

   // ---------------- transmitter ----------------
   logic [9:0]    tx_shift;
   logic          tx_busy;
   logic [BW-1:0] tx_baud;
   logic [3:0]    tx_bits;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_shift <= '1;
         tx_busy  <= 1'b0;
         tx_baud  <= '0;
         tx_bits  <= '0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!tx_busy) begin
            if (trmt) begin
               tx_shift <= {1'b1, tx_data, 1'b0};
               tx_busy  <= 1'b1;
               tx_baud  <= BAUD_MAX;
               tx_bits  <= '0;
            end
         end else if (tx_baud != '0) begin
            tx_baud <= tx_baud - 1'b1;
         end else begin
            tx_baud  <= BAUD_MAX;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bits  <= tx_bits + 1'b1;
            if (tx_bits == 4'd9) begin
               tx_busy <= 1'b0;
               tx_done <= 1'b1;
            end
         end
      end
   end

   assign TX = tx_shift[0];

endmodule

// File: rtl/uart_cmd_frame.sv
// Command framer over a UART: assembles CMD_BYTES received bytes into cmd,
// and serialises a RESP_BYTES response word MSB byte first.
// Ports: clk/rst, RX/TX serial; cmd/cmd_rdy/clr_cmd_rdy, resp/trmt/tx_busy/tx_done,
// frame_err (inter-byte timeout) and overrun (command dropped) pulses.
module uart_cmd_frame
   import uart_pkg::*;
#(
   parameter int CMD_BYTES  = 2,
   parameter int RESP_BYTES = 1,
   parameter int TIMEOUT    = 1000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    RX,
   output logic                    TX,
   output logic [8*CMD_BYTES-1:0]  cmd,
   output logic                    cmd_rdy,
   input  logic                    clr_cmd_rdy,
   input  logic [8*RESP_BYTES-1:0] resp,
   input  logic                    trmt,
   output logic                    tx_busy,
   output logic                    tx_done,
   output logic                    frame_err,
   output logic                    overrun
);

   localparam int CMD_W  = BYTE_W * CMD_BYTES;
   localparam int RESP_W = BYTE_W * RESP_BYTES;
   localparam int BCNT_W = $clog2(CMD_BYTES + 1);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam int TIDX_W = $clog2(RESP_BYTES + 1);
   localparam logic [BCNT_W-1:0] LAST_CMD_BYTE  = BCNT_W'(CMD_BYTES - 1);
   localparam logic [TCNT_W-1:0] TO_LAST        = TCNT_W'(TIMEOUT - 1);
   localparam logic [TIDX_W-1:0] LAST_RESP_BYTE = TIDX_W'(RESP_BYTES - 1);

   logic [BYTE_W-1:0] rx_data;
   logic              rx_rdy;
   logic              clr_rx_rdy;
   logic              u_trmt;
   logic [BYTE_W-1:0] u_tx_data;
   logic              u_tx_done;

   uart_cmd_frame_uart #(
      .DIV (BAUD_DIV)
   ) u_uart (
      .clk        (clk),
      .rst_n      (~rst),
      .RX         (RX),
      .TX         (TX),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (clr_rx_rdy),
      .trmt       (u_trmt),
      .tx_data    (u_tx_data),
      .tx_done    (u_tx_done)
   );

   // ---------------- RX framer ----------------
   rx_state_t         rx_state, rx_state_nxt;
   logic [BCNT_W-1:0] byte_cnt;
   logic [TCNT_W-1:0] to_cnt;
   logic [CMD_W-1:0]  asm_q, asm_nxt;
   logic              last_byte, cmd_done, timeout_hit;

   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_state_nxt;
   end

   // In IDLE byte_cnt is 0, so last_byte there means a one-byte command.
   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:    if (rx_rdy && !last_byte) rx_state_nxt = RX_COLLECT;
         RX_COLLECT: if ((rx_rdy && last_byte) || timeout_hit) rx_state_nxt = RX_IDLE;
         default:    rx_state_nxt = RX_IDLE;
      endcase
   end

   // A byte landing in the expiry cycle masks the timeout.
   always_comb begin
      clr_rx_rdy  = rx_rdy;
      last_byte   = (byte_cnt == LAST_CMD_BYTE);
      cmd_done    = rx_rdy && last_byte;
      timeout_hit = (rx_state == RX_COLLECT) && !rx_rdy && (to_cnt == TO_LAST);
      asm_nxt     = CMD_W'({asm_q, rx_data});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt  <= '0;
         to_cnt    <= '0;
         asm_q     <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= timeout_hit;
         overrun   <= cmd_done && cmd_rdy && !clr_cmd_rdy;
         if (rx_rdy) begin
            asm_q    <= asm_nxt;
            to_cnt   <= '0;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
         end else if (timeout_hit) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
         end else if (rx_state == RX_COLLECT) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (clr_cmd_rdy) cmd_rdy <= 1'b0;
         // A coincident acknowledge frees the slot, so the new command lands.
         if (cmd_done && !(cmd_rdy && !clr_cmd_rdy)) begin
            cmd     <= asm_nxt;
            cmd_rdy <= 1'b1;
         end
      end
   end

   // ---------------- TX sequencer ----------------
   tx_state_t         tx_state, tx_state_nxt;
   logic [RESP_W-1:0] resp_q;
   logic [TIDX_W-1:0] tx_idx;
   logic              last_resp;

   always_ff @(posedge clk) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_state_nxt;
   end

   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         TX_IDLE: if (trmt) tx_state_nxt = TX_SEND;
         TX_SEND: tx_state_nxt = TX_WAIT;
         TX_WAIT: if (u_tx_done) tx_state_nxt = last_resp ? TX_IDLE : TX_SEND;
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      u_trmt    = (tx_state == TX_SEND);
      u_tx_data = resp_q[RESP_W-1 -: BYTE_W];
      tx_busy   = (tx_state != TX_IDLE);
      last_resp = (tx_idx == LAST_RESP_BYTE);
   end

   // resp is captured once; the captured copy is shifted so the byte on
   // the wire is always the top byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_q  <= '0;
         tx_idx  <= '0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= (tx_state == TX_WAIT) && u_tx_done && last_resp;
         if (tx_state == TX_IDLE && trmt) begin
            resp_q <= resp;
            tx_idx <= '0;
         end else if (tx_state == TX_WAIT && u_tx_done && !last_resp) begin
            resp_q <= resp_q << BYTE_W;
            tx_idx <= tx_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_frame.sv
module tb_uart_cmd_frame;
   import uart_pkg::*;

   localparam int BIT_T = BAUD_DIV;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        rx_a, tx_a, cmd_rdy_a, clr_a, trmt_a, tx_busy_a, tx_done_a, frame_err_a, overrun_a;
   logic [15:0] cmd_a, resp_a;
   logic        rx_b, tx_b, cmd_rdy_b, clr_b, trmt_b, tx_busy_b, tx_done_b, frame_err_b, overrun_b;
   logic [31:0] cmd_b;
   logic [7:0]  resp_b;

   uart_cmd_frame #(.RESP_BYTES(2)) dut_a (
      .clk(clk), .rst(rst), .RX(rx_a), .TX(tx_a), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a),
      .clr_cmd_rdy(clr_a), .resp(resp_a), .trmt(trmt_a), .tx_busy(tx_busy_a),
      .tx_done(tx_done_a), .frame_err(frame_err_a), .overrun(overrun_a));

   uart_cmd_frame #(.CMD_BYTES(4), .TIMEOUT(5000)) dut_b (
      .clk(clk), .rst(rst), .RX(rx_b), .TX(tx_b), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b),
      .clr_cmd_rdy(clr_b), .resp(resp_b), .trmt(trmt_b), .tx_busy(tx_busy_b),
      .tx_done(tx_done_b), .frame_err(frame_err_b), .overrun(overrun_b));

   int n_checks = 0;
   int n_fail   = 0;
   int ovr_a = 0, ferr_a = 0, ferr_b = 0, tdone_a = 0, tdone_b = 0, ovr_b = 0;

   always @(posedge clk) begin
      if (overrun_a)   ovr_a   <= ovr_a + 1;
      if (overrun_b)   ovr_b   <= ovr_b + 1;
      if (frame_err_a) ferr_a  <= ferr_a + 1;
      if (frame_err_b) ferr_b  <= ferr_b + 1;
      if (tx_done_a)   tdone_a <= tdone_a + 1;
      if (tx_done_b)   tdone_b <= tdone_b + 1;
   end

   logic [31:0] exp_cmd_q[$];
   logic [7:0]  exp_tx_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   // Start bit plus eight data bits; leaves the line high (stop bit begun).
   task automatic send_bits(input bit sel, input logic [7:0] b);
      set_rx(sel, 1'b0);
      repeat (BIT_T) tick();
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, b[i]);
         repeat (BIT_T) tick();
      end
      set_rx(sel, 1'b1);
   endtask

   // Sends an nb-byte command, MSB byte first. exp is the cmd value required
   // one cycle after the final byte is delivered; exp_pre is cmd_rdy in the
   // delivery cycle; clr_co raises clr_cmd_rdy in exactly that cycle.
   task automatic send_cmd(input bit sel, input int nb, input logic [31:0] w,
                           input logic [31:0] exp, input logic exp_pre, input bit clr_co);
      bit got;
      logic [31:0] e;
      exp_cmd_q.push_back(exp);
      for (int k = nb - 1; k > 0; k--) begin
         send_bits(sel, w[8*k +: 8]);
         repeat (BIT_T) tick();
      end
      send_bits(sel, w[7:0]);
      got = 1'b0;
      for (int i = 0; i < 4 * BIT_T && !got; i++) begin
         tick();
         got = sel ? dut_b.rx_rdy : dut_a.rx_rdy;
      end
      chk("last_byte_delivered", {31'd0, got}, 32'd1);
      chk("cmd_rdy_in_delivery_cycle", {31'd0, sel ? cmd_rdy_b : cmd_rdy_a}, {31'd0, exp_pre});
      if (clr_co) begin
         if (sel) clr_b = 1'b1;
         else     clr_a = 1'b1;
      end
      tick();
      clr_a = 1'b0;
      clr_b = 1'b0;
      e = exp_cmd_q.pop_front();
      chk("cmd", sel ? cmd_b : {16'h0, cmd_a}, e);
      chk("cmd_rdy_after", {31'd0, sel ? cmd_rdy_b : cmd_rdy_a}, 32'd1);
      repeat (BIT_T) tick();
   endtask

   task automatic decode_tx(output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = 8'h00;
      for (int i = 0; i < 8 * BIT_T && !ok; i++) begin
         tick();
         if (tx_a === 1'b0) ok = 1'b1;
      end
      if (ok) begin
         repeat (BIT_T / 2) tick();
         if (tx_a !== 1'b0) ok = 1'b0;
         for (int k = 0; k < 8; k++) begin
            repeat (BIT_T) tick();
            b[k] = tx_a;
         end
         repeat (BIT_T) tick();
         if (tx_a !== 1'b1) ok = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] b;
      bit ok, got;
      logic busy_at_done;
      int base_done, base_ferr;

      rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
      trmt_a = 1'b0; trmt_b = 1'b0; resp_a = '0; resp_b = '0;
      repeat (3) tick();
      chk("rst_cmd_a", {16'h0, cmd_a}, 32'h0);
      chk("rst_cmd_rdy_a", {31'd0, cmd_rdy_a}, 32'd0);
      chk("rst_tx_busy_a", {31'd0, tx_busy_a}, 32'd0);
      chk("rst_tx_done_a", {31'd0, tx_done_a}, 32'd0);
      chk("rst_flags_a", {30'd0, frame_err_a, overrun_a}, 32'd0);
      chk("rst_tx_line_a", {31'd0, tx_a}, 32'd1);
      chk("rst_cmd_b", cmd_b, 32'h0);
      rst = 1'b0;
      repeat (5) tick();

      // Two-byte command and cmd_rdy level behaviour.
      send_cmd(1'b0, 2, 32'hA53C, 32'hA53C, 1'b0, 1'b0);
      repeat (30) tick();
      chk("cmd_rdy_holds", {31'd0, cmd_rdy_a}, 32'd1);
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      chk("cmd_rdy_cleared", {31'd0, cmd_rdy_a}, 32'd0);
      chk("cmd_held_after_clr", {16'h0, cmd_a}, 32'hA53C);

      // Overrun, then acceptance with a coincident acknowledge.
      send_cmd(1'b0, 2, 32'h0102, 32'h0102, 1'b0, 1'b0);
      send_cmd(1'b0, 2, 32'h0304, 32'h0102, 1'b1, 1'b0);
      chk("overrun_pulses", ovr_a, 1);
      send_cmd(1'b0, 2, 32'h0304, 32'h0304, 1'b1, 1'b1);
      chk("no_overrun_on_coincident_clr", ovr_a, 1);

      // Inter-byte timeout on the 4-byte instance, then a good frame.
      send_bits(1'b1, 8'h11); repeat (BIT_T) tick();
      send_bits(1'b1, 8'h22); repeat (BIT_T) tick();
      repeat (5100) tick();
      chk("frame_err_pulses", ferr_b, 1);
      chk("no_cmd_after_timeout", {31'd0, cmd_rdy_b}, 32'd0);
      send_cmd(1'b1, 4, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("no_frame_err_good_frame", ferr_b, 1);
      chk("no_overrun_b", ovr_b, 0);

      // Two-byte response, a second trmt mid-send must be ignored.
      base_done = tdone_a;
      resp_a = 16'hBEEF;
      trmt_a = 1'b1;
      exp_tx_q.push_back(8'hBE);
      exp_tx_q.push_back(8'hEF);
      tick();
      trmt_a = 1'b0;
      resp_a = 16'h1234;
      chk("tx_busy_after_trmt", {31'd0, tx_busy_a}, 32'd1);
      decode_tx(b, ok);
      chk("tx_frame0_ok", {31'd0, ok}, 32'd1);
      chk("tx_byte0", {24'd0, b}, {24'd0, exp_tx_q.pop_front()});
      trmt_a = 1'b1;
      tick();
      trmt_a = 1'b0;
      decode_tx(b, ok);
      chk("tx_frame1_ok", {31'd0, ok}, 32'd1);
      chk("tx_byte1", {24'd0, b}, {24'd0, exp_tx_q.pop_front()});
      got = 1'b0;
      busy_at_done = 1'b1;
      for (int i = 0; i < 4 * BIT_T && !got; i++) begin
         tick();
         if (tx_done_a === 1'b1) begin
            got = 1'b1;
            busy_at_done = tx_busy_a;
         end
      end
      chk("tx_done_seen", {31'd0, got}, 32'd1);
      chk("tx_busy_low_with_done", {31'd0, busy_at_done}, 32'd0);
      repeat (12 * BIT_T) tick();
      chk("tx_done_single", tdone_a - base_done, 1);
      chk("tx_idle_after", {31'd0, tx_busy_a}, 32'd0);

      // Reset mid-command and mid-response.
      resp_a = 16'hABCD;
      trmt_a = 1'b1;
      tick();
      trmt_a = 1'b0;
      send_bits(1'b0, 8'h77); repeat (BIT_T) tick();
      rx_a = 1'b0;
      repeat (3 * BIT_T) tick();
      chk("busy_before_rst", {31'd0, tx_busy_a}, 32'd1);
      base_done = tdone_a;
      base_ferr = ferr_a;
      rst = 1'b1;
      rx_a = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_cmd_a", {16'h0, cmd_a}, 32'h0);
      chk("mid_rst_cmd_rdy_a", {31'd0, cmd_rdy_a}, 32'd0);
      chk("mid_rst_tx_busy_a", {31'd0, tx_busy_a}, 32'd0);
      chk("mid_rst_tx_line_a", {31'd0, tx_a}, 32'd1);
      chk("mid_rst_pulses_a", {29'd0, tx_done_a, frame_err_a, overrun_a}, 32'd0);
      chk("mid_rst_cmd_b", cmd_b, 32'h0);
      chk("mid_rst_b_misc", {29'd0, cmd_rdy_b, tx_busy_b, tx_b}, 32'd1);
      repeat (20 * BIT_T) tick();
      chk("no_tx_done_after_rst", tdone_a - base_done, 0);
      chk("no_frame_err_after_rst", ferr_a - base_ferr, 0);
      chk("b_tx_quiet", tdone_b, 0);
      send_cmd(1'b0, 2, 32'h55AA, 32'h55AA, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_frame.md
UART_CMD_FRAME -- requirements
Module: uart_cmd_frame

Interface
REQ-001 SHALL provide parameter CMD_BYTES, default 2: number of bytes per received command, range 1..8.
REQ-002 SHALL provide parameter RESP_BYTES, default 1: number of bytes per transmitted response, range 1..8.
REQ-003 SHALL provide parameter TIMEOUT, default 1000000: inter-byte timeout in clk cycles, range 2..2^24.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 RX  in  1  serial receive line.
REQ-008 TX  out  1  serial transmit line.
REQ-009 cmd  out  8*CMD_BYTES  last accepted command; first-received byte in the MSBs.
REQ-010 cmd_rdy  out  1  level: cmd holds an unconsumed command.
REQ-011 clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
REQ-012 resp  in  8*RESP_BYTES  response word; MSB byte is sent first.
REQ-013 trmt  in  1  single-cycle pulse: start sending resp.
REQ-014 tx_busy  out  1  high while a response is in progress.
REQ-015 tx_done  out  1  single-cycle pulse after the last response byte completes.
REQ-016 frame_err  out  1  single-cycle pulse: partial command discarded on timeout.
REQ-017 overrun  out  1  single-cycle pulse: completed command dropped because cmd_rdy was still set.

Function
REQ-018 RX FSM states SHALL be IDLE and COLLECT; each UART rx_rdy SHALL be acknowledged with clr_rx_rdy in the same cycle.
- The byte SHALL shift into the assembly register.
- The byte count SHALL increment.
REQ-019 IDLE SHALL go to COLLECT on the first byte when CMD_BYTES>1; when CMD_BYTES=1, every byte SHALL complete a command directly.
REQ-020 On the CMD_BYTES-th byte, cmd SHALL load the assembled word and cmd_rdy SHALL rise on the next cycle (latency 1 from rx_rdy); the FSM SHALL return to IDLE.
REQ-021 In COLLECT, the timeout counter SHALL clear on each byte.
- On reaching TIMEOUT cycles without a byte: the partial frame SHALL be discarded, frame_err SHALL pulse, and the FSM SHALL go to IDLE.
- A byte arriving in the same cycle as expiry SHALL win; no error.
REQ-022 cmd_rdy SHALL clear the cycle after clr_cmd_rdy; cmd SHALL hold its value until the next accepted command.
REQ-023 Completion with cmd_rdy=1 and clr_cmd_rdy=0 SHALL drop the new command, hold cmd, and pulse overrun.
REQ-024 Completion in the same cycle as clr_cmd_rdy SHALL be accepted: cmd updates and cmd_rdy stays 1.
REQ-025 TX FSM states SHALL be IDLE, SEND and WAIT.
- On trmt in IDLE: capture resp, set tx_busy next cycle, go to SEND.
- SEND: pulse UART trmt with the current byte, then go to WAIT.
- WAIT: on UART tx_done, go to SEND for the next byte, or finish after the last byte.
REQ-026 After the last byte, tx_done SHALL pulse and tx_busy SHALL fall in the same cycle.
REQ-027 trmt while tx_busy=1 SHALL be ignored; resp changes after capture SHALL have no effect.
REQ-028 The RX and TX paths SHALL operate concurrently and independently.

Reset
REQ-029 On rst, the following SHALL reset:
- Both FSMs to IDLE.
- Byte and timeout counters to 0.
- cmd to 0.
- cmd_rdy, tx_busy, tx_done, frame_err and overrun to 0.
- TX idle high.
REQ-030 rst mid-frame or mid-response SHALL discard all progress, with no frame_err and no tx_done.

Structure
REQ-031 The RX/TX state enums SHALL live in shared package uart_pkg, together with the byte-width constant 8.
REQ-032 The block SHALL instantiate exactly one sub-module, the team's existing UART transceiver, with rst_n driven by ~rst.
REQ-033 The counter widths SHALL be derived by $clog2 from the parameters.

Verification
REQ-034 Defaults; send bytes 0xA5 then 0x3C -> cmd=0xA53C; cmd_rdy rises 1 cycle after the second rx_rdy and holds until clr_cmd_rdy.
REQ-035 CMD_BYTES=4, TIMEOUT=5000; send 0x11, 0x22, then idle 5000 cycles -> frame_err pulses once; then send 0xDE 0xAD 0xBE 0xEF -> cmd=0xDEADBEEF.
REQ-036 Complete 0x0102 with no clr, then complete 0x0304 -> overrun pulses and cmd stays 0x0102; repeat with clr_cmd_rdy coincident with completion -> cmd=0x0304, cmd_rdy=1.
REQ-037 RESP_BYTES=2; resp=0xBEEF with trmt -> TX sends 0xBE then 0xEF; second trmt mid-send is ignored; a single tx_done pulse follows, with tx_busy low the same cycle.
REQ-038 Assert rst while the second command byte is being received and during TX -> all outputs read their reset values the next cycle; the following 0x55AA command is assembled correctly.
